ieee_to_fp_pipe: RTL and testbench
==================================

IEEE_TO_FP_PIPE -- requirements
Module: ieee_to_fp_pipe

Interface
REQ-001 SHALL have parameter DataWidth, default 32, giving the IEEE 754 operand width; only 16 (wE=5, wF=10) and 32 (wE=8, wF=23) are legal.
REQ-002 SHALL have parameter CntWidth, default 16, giving the width of the flush counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ieee_i  input  DataWidth  IEEE 754 operand {sign, exponent, fraction}.
REQ-006 SHALL have port valid_i  input  1  ieee_i valid.
REQ-007 SHALL have port ready_o  output  1  block accepts ieee_i this cycle.
REQ-008 SHALL have port fp_o  output  DataWidth+2  FloPoCo operand {exc[1:0], sign, exponent, fraction}.
REQ-009 SHALL have port flushed_o  output  1  fp_o came from a flushed subnormal.
REQ-010 SHALL have port valid_o  output  1  fp_o/flushed_o valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts fp_o.
REQ-012 SHALL have port flush_cnt_o  output  CntWidth  count of subnormals flushed since reset.
REQ-013 SHALL have port flush_cnt_clr_i  input  1  synchronous clear of flush_cnt_o.

Function
REQ-014 SHALL classify the input: exp=0 and frac=0 gives exc=00 (zero); exp=0 and frac!=0 gives exc=00 with flushed=1; exp all-ones and frac=0 gives exc=10 (inf); exp all-ones and frac!=0 gives exc=11 (NaN); all other inputs give exc=01 (normal).
REQ-015 SHALL copy the sign bit into fp_o for every class.
REQ-016 SHALL copy the exponent and fraction unchanged when exc=01, and SHALL drive them to zero for all other classes.
REQ-017 SHALL be a two-stage pipeline: stage 1 registers the classification and fields, stage 2 registers the packed fp_o and flushed_o; latency is exactly 2 cycles when ready_i=1.
REQ-018 SHALL transfer a beat on each handshake when valid and ready are both 1 on a rising edge, at both ports.
REQ-019 SHALL allow each stage to load when it is empty or when its contents leave in the same cycle; ready_o SHALL equal the load condition of stage 1.
REQ-020 SHALL sustain one beat per cycle when ready_i is held at 1.
REQ-021 SHALL hold fp_o, flushed_o and valid_o stable while valid_o=1 and ready_i=0; no beat is dropped or duplicated.
REQ-022 SHALL not let valid_o depend combinationally on ready_i; ready_o may depend combinationally on ready_i.
REQ-023 SHALL increment flush_cnt_o by 1 when a flushed beat is accepted at the input, saturating at all-ones.
REQ-024 SHALL make flush_cnt_clr_i take priority over a simultaneous increment, giving 0.
REQ-025 SHALL raise an elaboration-time $error for an unsupported DataWidth.

Reset
REQ-026 SHALL, while rst_ni=0 at a clock edge, clear both stage valid bits, set valid_o=0, flushed_o=0, fp_o=0 and flush_cnt_o=0; ready_o reads 1 in the first cycle after reset.
REQ-027 SHALL discard all in-flight beats when reset is asserted mid-operation, with none emitted after release.

Structure
REQ-028 SHALL place the exc encoding constants (ZERO=00, NORMAL=01, INF=10, NAN=11) and the per-DataWidth wE/wF functions in shared package flopoco_pkg.
REQ-029 SHALL implement the per-stage valid/ready register as one reusable sub-module, fp_pipe_reg, instantiated twice.

Verification
REQ-030 SHALL check, with DataWidth=32, that input 0x3F800000 yields fp_o=0x13F800000 and flushed_o=0, two cycles after acceptance.
REQ-031 SHALL check that inputs 0x80000000, 0x7F800000, 0x7FC00000 and 0xFF800000 yield 0x080000000, 0x200000000, 0x300000000 and 0x280000000 respectively.
REQ-032 SHALL check that input 0x00000001 yields fp_o=0x000000000 with flushed_o=1 and flush_cnt_o going 0 to 1; a simultaneous flush and clear leaves 0.
REQ-033 SHALL check back-to-back stimulus: 4 beats with ready_i=0 for 3 cycles, then 1; all 4 outputs emerge in order, ready_o goes low after 2 beats are held, and there is no loss.
REQ-034 SHALL check a reset pulse with 2 beats in flight: valid_o=0 the next cycle, and the first beat after release arrives with 2-cycle latency.
REQ-035 SHALL check, with DataWidth=16, that 0x3C00 yields 0x13C00 and 0x7E00 yields 0x30000.

Source files
------------

// File: rtl/flopoco_pkg.sv
// Shared FloPoCo definitions: exception encoding and per-width IEEE field sizes.
package flopoco_pkg;

  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

  // Exponent field width for a supported IEEE operand width.
  function automatic int exp_w(input int data_w);
    return (data_w == 16) ? 5 : 8;
  endfunction

  // Fraction field width for a supported IEEE operand width.
  function automatic int frac_w(input int data_w);
    return (data_w == 16) ? 10 : 23;
  endfunction

endpackage

// File: rtl/ieee_to_fp_pipe_if.sv
// Valid/ready handshake bundle linking pipeline stages.
interface ieee_to_fp_pipe_if;
  logic valid;
  logic ready;

  modport master (output valid, input ready);
  modport slave  (input valid, output ready);
endinterface

// File: rtl/fp_pipe_reg.sv
// One elastic pipeline stage: payload register plus valid bit with valid/ready flow control.
module fp_pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ieee_to_fp_pipe_if.slave    up,
  ieee_to_fp_pipe_if.master   dn,
  input  logic [DATA_W-1:0]   d,
  output logic [DATA_W-1:0]   q
);

  logic vld;
  logic load;

  // The stage may take a new beat when empty or when its current beat leaves this cycle.
  assign load     = !vld || dn.ready;
  assign up.ready = load;
  assign dn.valid = vld;

  // Capture the upstream beat on load; payload is cleared on reset so outputs read zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= up.valid;
      if (up.valid) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/ieee_to_fp_pipe.sv
// IEEE 754 to FloPoCo format converter: two-stage elastic pipeline with subnormal flush counter.
module ieee_to_fp_pipe
  import flopoco_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] ieee_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth+1:0] fp_o,
  output logic                 flushed_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CntWidth-1:0]  flush_cnt_o,
  input  logic                 flush_cnt_clr_i
);

  localparam int WE = exp_w(DataWidth);
  localparam int WF = frac_w(DataWidth);
  localparam int PW = DataWidth + 3;

  if (DataWidth != 16 && DataWidth != 32) begin : g_bad_width
    $error("ieee_to_fp_pipe: unsupported DataWidth %0d (use 16 or 32)", DataWidth);
  end

  ieee_to_fp_pipe_if hs_in ();
  ieee_to_fp_pipe_if hs_mid ();
  ieee_to_fp_pipe_if hs_out ();

  logic                 sign_p0;
  logic [WE-1:0]        exp_p0;
  logic [WF-1:0]        frac_p0;
  exc_e                 exc_p0;
  logic                 flushed_p0;
  logic [PW-1:0]        pl_p0;
  logic [PW-1:0]        pl_p1;
  logic [PW-1:0]        pl_p2_d;
  logic [PW-1:0]        pl_p2;
  logic [1:0]           exc_p1;
  logic [DataWidth-1:0] body_p1;
  logic                 flushed_p1;
  logic                 vld_p1;
  logic                 vld_p2;
  logic                 acc_p0;

  assign {sign_p0, exp_p0, frac_p0} = ieee_i;

  // Stage 0 -> 1: classify the raw operand.
  always_comb begin
    exc_p0     = EXC_NORMAL;
    flushed_p0 = 1'b0;
    if (exp_p0 == '0) begin
      exc_p0     = EXC_ZERO;
      flushed_p0 = |frac_p0;
    end else if (&exp_p0) begin
      exc_p0 = (|frac_p0) ? EXC_NAN : EXC_INF;
    end
  end

  assign pl_p0       = {exc_p0, ieee_i, flushed_p0};
  assign hs_in.valid = valid_i;
  assign ready_o     = hs_in.ready;
  assign acc_p0      = valid_i && hs_in.ready;

  fp_pipe_reg #(.DATA_W(PW)) u_stage1 (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .up    (hs_in),
    .dn    (hs_mid),
    .d     (pl_p0),
    .q     (pl_p1)
  );

  assign exc_p1     = pl_p1[PW-1 -: 2];
  assign body_p1    = pl_p1[DataWidth:1];
  assign flushed_p1 = pl_p1[0];
  assign vld_p1     = hs_mid.valid;

  // Stage 1 -> 2: pack FloPoCo word, zeroing exponent/fraction for non-normal classes.
  always_comb begin
    pl_p2_d = '0;
    pl_p2_d[PW-1 -: 2]      = exc_p1;
    pl_p2_d[DataWidth]      = body_p1[DataWidth-1];
    pl_p2_d[0]              = flushed_p1;
    if (exc_p1 == EXC_NORMAL) begin
      pl_p2_d[DataWidth-1:1] = body_p1[DataWidth-2:0];
    end
  end

  fp_pipe_reg #(.DATA_W(PW)) u_stage2 (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .up    (hs_mid),
    .dn    (hs_out),
    .d     (pl_p2_d),
    .q     (pl_p2)
  );

  assign vld_p2       = hs_out.valid;
  assign hs_out.ready = ready_i;
  assign valid_o      = vld_p2;
  assign fp_o         = pl_p2[PW-1:1];
  assign flushed_o    = pl_p2[0];

  // Count flushed subnormals accepted at the input; clear wins, count saturates.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flush_cnt_o <= '0;
    end else if (flush_cnt_clr_i) begin
      flush_cnt_o <= '0;
    end else if (acc_p0 && flushed_p0 && (flush_cnt_o != '1)) begin
      flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_ieee_to_fp_pipe.sv
// Scoreboard bench for ieee_to_fp_pipe (32-bit instance plus a 16-bit instance).
module tb_ieee_to_fp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic [31:0] ieee_i;
  logic [33:0] fp_o;
  logic        flushed_o;
  logic [15:0] flush_cnt_o;
  logic        flush_cnt_clr_i;

  ieee_to_fp_pipe_if in_hs ();
  ieee_to_fp_pipe_if out_hs ();

  ieee_to_fp_pipe #(.DataWidth(32), .CntWidth(16)) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .ieee_i          (ieee_i),
    .valid_i         (in_hs.valid),
    .ready_o         (in_hs.ready),
    .fp_o            (fp_o),
    .flushed_o       (flushed_o),
    .valid_o         (out_hs.valid),
    .ready_i         (out_hs.ready),
    .flush_cnt_o     (flush_cnt_o),
    .flush_cnt_clr_i (flush_cnt_clr_i)
  );

  logic [15:0] ieee16;
  logic        valid16;
  logic        ready_o16;
  logic [17:0] fp16;
  logic        flushed16;
  logic        valid_o16;
  logic [15:0] cnt16;

  ieee_to_fp_pipe #(.DataWidth(16), .CntWidth(16)) u_dut16 (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .ieee_i          (ieee16),
    .valid_i         (valid16),
    .ready_o         (ready_o16),
    .fp_o            (fp16),
    .flushed_o       (flushed16),
    .valid_o         (valid_o16),
    .ready_i         (1'b1),
    .flush_cnt_o     (cnt16),
    .flush_cnt_clr_i (1'b0)
  );

  typedef struct {
    logic [33:0] fp;
    logic        fl;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_pop = 0;
  bit   chk_lat = 1'b0;

  function automatic exp_t model(input logic [31:0] v, input int acc);
    exp_t r;
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
    s = v[31];
    e = v[30:23];
    f = v[22:0];
    r.acc = acc;
    r.fl  = 1'b0;
    if (e == 8'h00) begin
      r.fp = {2'b00, s, 31'd0};
      r.fl = (f != 23'd0);
    end else if (e == 8'hFF) begin
      r.fp = {((f == 23'd0) ? 2'b10 : 2'b11), s, 31'd0};
    end else begin
      r.fp = {2'b01, v};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (rst_ni) begin
      if (out_hs.valid && out_hs.ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          n_pop++;
          chk("fp", fp_o, e.fp);
          chk("flushed", flushed_o, e.fl);
          if (chk_lat) chk("latency", cyc - e.acc, 2);
        end
      end
      if (in_hs.valid && in_hs.ready) sb.push_back(model(ieee_i, cyc));
    end
  end

  task automatic send(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    ieee_i = v;
    in_hs.valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_hs.ready && rst_ni;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_hs.valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_vals [4];
  logic [33:0] held_fp;
  int          pops0;

  initial begin
    rst_ni = 1'b0;
    ieee_i = '0;
    in_hs.valid = 1'b0;
    out_hs.ready = 1'b1;
    flush_cnt_clr_i = 1'b0;
    ieee16 = '0;
    valid16 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", out_hs.valid, 0);
    chk("rst_fp_o", fp_o, 0);
    chk("rst_flushed_o", flushed_o, 0);
    chk("rst_flush_cnt", flush_cnt_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready_o", in_hs.ready, 1);
    @(posedge clk);
    #1;

    // Classes with fixed latency
    chk_lat = 1'b1;
    send(32'h3F800000);
    send(32'h80000000);
    send(32'h7F800000);
    send(32'h7FC00000);
    send(32'hFF800000);
    send(32'hC2C80000);
    drain();

    // Flush counter
    chk("cnt_before", flush_cnt_o, 0);
    send(32'h00000001);
    chk("cnt_inc", flush_cnt_o, 1);
    send(32'h80400000);
    chk("cnt_inc2", flush_cnt_o, 2);
    drain();
    flush_cnt_clr_i = 1'b1;
    send(32'h00000001);
    flush_cnt_clr_i = 1'b0;
    chk("cnt_clr_prio", flush_cnt_o, 0);
    drain();

    // Back-to-back with downstream stall
    chk_lat = 1'b0;
    b2b_vals[0] = 32'h40490FDB;
    b2b_vals[1] = 32'h00000010;
    b2b_vals[2] = 32'hFFC00001;
    b2b_vals[3] = 32'h3EAAAAAB;
    pops0 = n_pop;
    out_hs.ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(b2b_vals[i]);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_ready_low", in_hs.ready, 0);
        chk("b2b_valid_held", out_hs.valid, 1);
        held_fp = fp_o;
        @(posedge clk);
        #1;
        chk("b2b_fp_stable", fp_o, held_fp);
        chk("b2b_valid_stable", out_hs.valid, 1);
        out_hs.ready = 1'b1;
      end
    join
    drain();
    chk("b2b_count", n_pop - pops0, 4);

    // Random stimulus with random downstream backpressure
    pops0 = n_pop;
    fork
      begin
        for (int i = 0; i < 20; i++) send($urandom());
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk);
          #1;
          out_hs.ready = 1'($urandom_range(0, 1));
        end
        out_hs.ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", n_pop - pops0, 20);

    // Reset with two beats in flight
    out_hs.ready = 1'b0;
    send(32'h41200000);
    send(32'h42C80000);
    rst_ni = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_valid_o", out_hs.valid, 0);
    rst_ni = 1'b1;
    out_hs.ready = 1'b1;
    chk_lat = 1'b1;
    pops0 = n_pop;
    send(32'h3F000000);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_pops", n_pop - pops0, 1);
    chk("midrst_idle", out_hs.valid, 0);

    // 16-bit instance
    ieee16 = 16'h3C00;
    valid16 = 1'b1;
    @(posedge clk);
    #1;
    valid16 = 1'b0;
    @(posedge clk);
    #1;
    chk("h_valid_a", valid_o16, 1);
    chk("h_fp_a", fp16, 18'h13C00);
    chk("h_flushed_a", flushed16, 0);
    ieee16 = 16'h7E00;
    valid16 = 1'b1;
    @(posedge clk);
    #1;
    valid16 = 1'b0;
    @(posedge clk);
    #1;
    chk("h_valid_b", valid_o16, 1);
    chk("h_fp_b", fp16, 18'h30000);
    chk("h_cnt", cnt16, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
